// File: rtl/ppt_slide_ctrl.sv
// Presentation-clicker sequencer: debounced next/prev/home buttons -> slide counter + key codes.
// Latency: press event to slide/key_valid update is 1 cycle; debounce adds 2 sync + DB_CYCLES.
// Backpressure: key_valid/key_code held until key_ready; presses during SEND/HOLDOFF are dropped.
//
// Ports: clk/rst (sync, active-high), ena (gates acceptance of new events only),
//        btn_next/btn_prev/btn_home (raw async buttons), key_ready/key_valid/key_code
//        (handshake to key sender, 01=next 10=prev 11=home), slide (current number),
//        seg (hex 7-seg of slide, {g,f,e,d,c,b,a}), busy (FSM not idle).
// Optional macro PPT_WRAP_EN: next at SLIDE_MAX wraps to 0, prev at 0 wraps to SLIDE_MAX.
module ppt_slide_ctrl #(
    parameter int DB_CYCLES      = 1000,
    parameter int SLIDE_MAX      = 15,
    parameter int HOLDOFF_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       btn_home,
    input  logic       key_ready,
    output logic       key_valid,
    output logic [1:0] key_code,
    output logic [3:0] slide,
    output logic [6:0] seg,
    output logic       busy
);
    localparam int DW = $clog2(DB_CYCLES + 1);
    localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SEND, HOLDOFF} state_t;

    // Button vector index: 0 = next, 1 = prev, 2 = home.
    logic [2:0]    btn;
    logic [2:0]    sync1, sync2, stable, press;
    logic [DW-1:0] db_cnt [3];

    state_t        state, state_nxt;
    logic [HW-1:0] hold_cnt;
    logic          accept;
    logic [3:0]    slide_nxt;
    logic [1:0]    code_nxt;

    assign btn = {btn_home, btn_prev, btn_next};

    // Synchroniser and debounce. press is a registered one-cycle pulse on a 0->1 flip.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
            press  <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= '0;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DW'(DB_CYCLES - 1)) begin
                    db_cnt[i] <= '0;
                    stable[i] <= ~stable[i];
                    press[i]  <= ~stable[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Event arbitration (home > prev > next) and slide arithmetic. Priority is
    // resolved before the boundary check, so a lower-priority event never
    // substitutes for an ignored boundary event.
    always_comb begin
        accept    = 1'b0;
        slide_nxt = slide;
        code_nxt  = key_code;
        if (state == IDLE && ena) begin
            if (press[2]) begin
                accept    = 1'b1;
                slide_nxt = 4'd0;
                code_nxt  = 2'b11;
            end else if (press[1]) begin
                if (slide != 4'd0) begin
                    accept    = 1'b1;
                    slide_nxt = slide - 4'd1;
                    code_nxt  = 2'b10;
                end else begin
`ifdef PPT_WRAP_EN
                    accept    = 1'b1;
                    slide_nxt = 4'(SLIDE_MAX);
                    code_nxt  = 2'b10;
`endif
                end
            end else if (press[0]) begin
                if (slide < 4'(SLIDE_MAX)) begin
                    accept    = 1'b1;
                    slide_nxt = slide + 4'd1;
                    code_nxt  = 2'b01;
                end else begin
`ifdef PPT_WRAP_EN
                    accept    = 1'b1;
                    slide_nxt = 4'd0;
                    code_nxt  = 2'b01;
`endif
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SEND;
            SEND:    if (key_ready) state_nxt = (HOLDOFF_CYCLES == 0) ? IDLE : HOLDOFF;
            HOLDOFF: if (hold_cnt == HW'(HOLDOFF_CYCLES - 1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        key_valid = (state == SEND);
        busy      = (state != IDLE);
    end

    // Datapath registers: slide/key_code only move on an accepted event.
    always_ff @(posedge clk) begin
        if (rst) begin
            slide    <= 4'd0;
            key_code <= 2'b00;
            hold_cnt <= '0;
        end else begin
            if (accept) begin
                slide    <= slide_nxt;
                key_code <= code_nxt;
            end
            if (state == HOLDOFF) hold_cnt <= hold_cnt + 1'b1;
            else                  hold_cnt <= '0;
        end
    end

    // Hex digit decode, segments {g,f,e,d,c,b,a}.
    always_comb begin
        case (slide)
            4'h0: seg = 7'b0111111;
            4'h1: seg = 7'b0000110;
            4'h2: seg = 7'b1011011;
            4'h3: seg = 7'b1001111;
            4'h4: seg = 7'b1100110;
            4'h5: seg = 7'b1101101;
            4'h6: seg = 7'b1111101;
            4'h7: seg = 7'b0000111;
            4'h8: seg = 7'b1111111;
            4'h9: seg = 7'b1101111;
            4'hA: seg = 7'b1110111;
            4'hB: seg = 7'b1111100;
            4'hC: seg = 7'b0111001;
            4'hD: seg = 7'b1011110;
            4'hE: seg = 7'b1111001;
            default: seg = 7'b1110001;
        endcase
    end
endmodule

// File: tb/tb_ppt_slide_ctrl.sv
// Randomized bench for ppt_slide_ctrl against a behavioural reference model.
// Latency: model advances once per clock; outputs compared on the falling edge.
// Backpressure: key_ready randomly withheld to exercise the SEND hold.
module tb_ppt_slide_ctrl;
    localparam int DB   = 4;
    localparam int HOLD = 2;
    localparam int SMAX = 15;
    localparam int NCYC = 6000;

    logic       clk = 1'b0;
    logic       rst, ena, btn_next, btn_prev, btn_home, key_ready;
    logic       key_valid, busy;
    logic [1:0] key_code;
    logic [3:0] slide;
    logic [6:0] seg;

    ppt_slide_ctrl #(.DB_CYCLES(DB), .SLIDE_MAX(SMAX), .HOLDOFF_CYCLES(HOLD)) dut (
        .clk(clk), .rst(rst), .ena(ena),
        .btn_next(btn_next), .btn_prev(btn_prev), .btn_home(btn_home),
        .key_ready(key_ready), .key_valid(key_valid), .key_code(key_code),
        .slide(slide), .seg(seg), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Hex font {g,f,e,d,c,b,a}.
    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model state.
    bit          d1 [3], d2 [3], stab [3], m_press [3];
    bit [DB-1:0] win [3];          // last DB synchronised samples seen by the debouncer
    bit          m_sending;
    int          m_hold, m_slide, m_code, n_accept;

    // Inputs as sampled on the edge the model is advancing over.
    bit s_rst, s_ena, s_kr;
    bit s_btn [3];

    task automatic model_reset();
        for (int b = 0; b < 3; b++) begin
            d1[b] = 0; d2[b] = 0; stab[b] = 0; m_press[b] = 0; win[b] = '0;
        end
        m_sending = 0; m_hold = 0; m_slide = 0; m_code = 0;
    endtask

    task automatic model_step();
        bit seen;
        bit newp [3];
        if (s_rst) begin
            model_reset();
            return;
        end
        // Sequencer, acting on presses detected on the previous edge.
        if (m_sending) begin
            if (s_kr) begin
                m_sending = 0;
                m_hold    = HOLD;
            end
        end else if (m_hold > 0) begin
            m_hold--;
        end else if (s_ena) begin
            if (m_press[2]) begin
                m_slide = 0; m_code = 3; m_sending = 1;
            end else if (m_press[1]) begin
                if (m_slide > 0) begin
                    m_slide--; m_code = 2; m_sending = 1;
                end else begin
`ifdef PPT_WRAP_EN
                    m_slide = SMAX; m_code = 2; m_sending = 1;
`endif
                end
            end else if (m_press[0]) begin
                if (m_slide < SMAX) begin
                    m_slide++; m_code = 1; m_sending = 1;
                end else begin
`ifdef PPT_WRAP_EN
                    m_slide = 0; m_code = 1; m_sending = 1;
`endif
                end
            end
            if (m_sending) n_accept++;
        end
        // Debounce: the stable level flips once the last DB synchronised
        // samples (two-cycle delayed raw input) all disagree with it.
        for (int b = 0; b < 3; b++) begin
            seen   = d2[b];
            d2[b]  = d1[b];
            d1[b]  = s_btn[b];
            win[b] = {win[b][DB-2:0], seen};
            newp[b] = 0;
            if (win[b] == (stab[b] ? {DB{1'b0}} : {DB{1'b1}})) begin
                stab[b] = ~stab[b];
                newp[b] = stab[b];
            end
        end
        for (int b = 0; b < 3; b++) m_press[b] = newp[b];
    endtask

    int blen [3];
    bit blvl [3];

    initial begin
        int mode;
        bit en_mask [3];
        n_accept = 0;
        model_reset();
        rst = 1; ena = 0; key_ready = 1; btn_next = 0; btn_prev = 0; btn_home = 0;
        for (int b = 0; b < 3; b++) begin blen[b] = 0; blvl[b] = 0; end

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            if (cyc >= 2) begin
                chk("key_valid", int'(key_valid), int'(m_sending));
                chk("busy",      int'(busy),      int'(m_sending || m_hold > 0));
                chk("slide",     int'(slide),     m_slide);
                chk("key_code",  int'(key_code),  m_code);
                chk("seg",       int'(seg),       int'(seg_tab[m_slide]));
            end

            // Phases bias the buttons so both slide boundaries get reached.
            mode = (cyc / 300) % 3;
            en_mask[0] = (mode != 1);
            en_mask[1] = (mode != 0);
            en_mask[2] = (mode == 2);
            for (int b = 0; b < 3; b++) begin
                if (blen[b] == 0) begin
                    if (en_mask[b]) begin
                        blvl[b] = 1'($urandom_range(0, 1));
                        blen[b] = $urandom_range(1, 12);
                    end else begin
                        blvl[b] = 0;
                        blen[b] = 5;
                    end
                end
                blen[b]--;
            end
            btn_next  = blvl[0];
            btn_prev  = blvl[1];
            btn_home  = blvl[2];
            ena       = ($urandom_range(0, 9) < 9);
            key_ready = ($urandom_range(0, 9) < 6);
            rst       = (cyc < 2) || ($urandom_range(0, 499) == 0);

            s_rst = rst; s_ena = ena; s_kr = key_ready;
            s_btn[0] = btn_next; s_btn[1] = btn_prev; s_btn[2] = btn_home;

            @(posedge clk);
            model_step();
        end

        // The random run must actually have produced key transfers.
        total++;
        if (n_accept < 20) begin
            bad++;
            $display("FAIL accept_count observed=%0d expected>=20", n_accept);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
